// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered result/flags and bit-serial shifts/rotates.
// Define ALU_SEQ_MUL_EN to add the shift-add multiplier (op 12); otherwise op 12 is illegal.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_50M,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // SHIFT | one bit of shift/rotate per cycle, r_cnt counts down
  // MUL   | one shift-add step per cycle (ALU_SEQ_MUL_EN only)
  // DONE  | result valid, held until out_ready

  localparam int LOG_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_FULL = {1'b1, {LOG_W{1'b0}}};

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;
  localparam logic [3:0] OP_ROL = 4'd10;
  localparam logic [3:0] OP_ROR = 4'd11;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd12;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
`ifdef ALU_SEQ_MUL_EN
    ST_MUL,
`endif
    ST_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [WIDTH-1:0] r_work;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_illegal;

  logic             w_accept;
  logic             w_is_shift;
  logic             w_big;
  logic [CNT_W-1:0] w_start_cnt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_sc_result;
  logic             w_sc_cf;
  logic             w_sc_vf;
  logic             w_sc_illegal;
  logic [3:0]       w_sc_flags;
  logic [WIDTH-1:0] w_step;
  logic             w_step_cf;

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_hi;
  logic             w_is_mul;
  logic [WIDTH:0]   w_madd;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;
`endif

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};
  // WIDTH is a power of two, so b >= WIDTH iff any bit at or above LOG_W is set
  assign w_big  = |b[WIDTH-1:LOG_W];

  always_comb begin
    w_is_shift   = 1'b0;
    w_start_cnt  = '0;
    w_sc_result  = '0;
    w_sc_cf      = 1'b0;
    w_sc_vf      = 1'b0;
    w_sc_illegal = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    w_is_mul     = 1'b0;
`endif
    case (op)
      OP_ADD: begin
        w_sc_result = w_sum[WIDTH-1:0];
        w_sc_cf     = w_sum[WIDTH];
        w_sc_vf     = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_sc_result = w_diff[WIDTH-1:0];
        w_sc_cf     = w_diff[WIDTH];
        w_sc_vf     = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: w_sc_result = a & b;
      OP_OR:  w_sc_result = a | b;
      OP_XOR: w_sc_result = a ^ b;
      OP_NOT: w_sc_result = ~a;
      OP_SLL, OP_SRL, OP_SRA: begin
        w_is_shift  = 1'b1;
        w_start_cnt = w_big ? CNT_FULL : {1'b0, b[LOG_W-1:0]};
        w_sc_result = a;
      end
      OP_ROL, OP_ROR: begin
        w_is_shift  = 1'b1;
        w_start_cnt = {1'b0, b[LOG_W-1:0]};
        w_sc_result = a;
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: begin
        w_is_mul    = 1'b1;
        w_start_cnt = CNT_FULL;
      end
`endif
      default: w_sc_illegal = 1'b1;
    endcase
  end

  assign w_sc_flags = {w_sc_cf, (w_sc_result == '0), w_sc_result[WIDTH-1], w_sc_vf};

  always_comb begin
    w_step    = r_work;
    w_step_cf = 1'b0;
    case (r_op)
      OP_SLL: begin
        w_step    = {r_work[WIDTH-2:0], 1'b0};
        w_step_cf = r_work[WIDTH-1];
      end
      OP_SRL: begin
        w_step    = {1'b0, r_work[WIDTH-1:1]};
        w_step_cf = r_work[0];
      end
      OP_SRA: begin
        w_step    = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
        w_step_cf = r_work[0];
      end
      OP_ROL: begin
        w_step    = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
        w_step_cf = r_work[WIDTH-1];
      end
      OP_ROR: begin
        w_step    = {r_work[0], r_work[WIDTH-1:1]};
        w_step_cf = r_work[0];
      end
      default: ;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  // {r_hi, r_work} holds partial product and remaining multiplier bits
  assign w_madd   = {1'b0, r_hi} + (r_work[0] ? {1'b0, r_a} : '0);
  assign w_mul_hi = w_madd[WIDTH:1];
  assign w_mul_lo = {w_madd[0], r_work[WIDTH-1:1]};
`endif

  assign w_accept = in_valid && (r_state == ST_IDLE);

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          if (w_is_shift && (w_start_cnt != '0)) begin
            w_next_state = ST_SHIFT;
          end
`ifdef ALU_SEQ_MUL_EN
          else if (w_is_mul) begin
            w_next_state = ST_MUL;
          end
`endif
          else begin
            w_next_state = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        if (r_cnt == CNT_ONE) w_next_state = ST_DONE;
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: begin
        if (r_cnt == CNT_ONE) w_next_state = ST_DONE;
      end
`endif
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // result/flags only change when entering DONE, never mid-operation
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      r_work    <= '0;
      r_cnt     <= '0;
      r_op      <= '0;
      r_result  <= '0;
      r_flags   <= '0;
      r_illegal <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_a       <= '0;
      r_hi      <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_op   <= op;
        r_work <= a;
        r_cnt  <= w_start_cnt;
`ifdef ALU_SEQ_MUL_EN
        r_a  <= a;
        r_hi <= '0;
        if (w_is_mul) r_work <= b;
`endif
        if (w_next_state == ST_DONE) begin
          r_result  <= w_sc_result;
          r_flags   <= w_sc_flags;
          r_illegal <= w_sc_illegal;
        end
      end else if (r_state == ST_SHIFT) begin
        r_work <= w_step;
        r_cnt  <= r_cnt - 1'b1;
        if (r_cnt == CNT_ONE) begin
          r_result  <= w_step;
          r_flags   <= {w_step_cf, (w_step == '0), w_step[WIDTH-1], 1'b0};
          r_illegal <= 1'b0;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      else if (r_state == ST_MUL) begin
        r_work <= w_mul_lo;
        r_hi   <= w_mul_hi;
        r_cnt  <= r_cnt - 1'b1;
        if (r_cnt == CNT_ONE) begin
          r_result  <= w_mul_lo;
          r_flags   <= {(w_mul_hi != '0), (w_mul_lo == '0), w_mul_lo[WIDTH-1], 1'b0};
          r_illegal <= 1'b0;
        end
      end
`endif
    end
  end

  assign result  = r_result;
  assign flags   = r_flags;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): directed vectors, randomized ops against a
// behavioural model, backpressure and mid-operation reset.
module tb_alu_seq;
  localparam int W = 16;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;
  localparam logic [3:0] OP_ROL = 4'd10;
  localparam logic [3:0] OP_ROR = 4'd11;

  logic         clk_50M = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         illegal;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #10 clk_50M = ~clk_50M;

  alu_seq #(.WIDTH(W)) dut (
    .clk_50M   (clk_50M),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .illegal   (illegal),
    .busy      (busy)
  );

  // Reference behaviour from the arithmetic definition of each op
  function automatic void model(input logic [3:0] m_op, input logic [W-1:0] m_a, input logic [W-1:0] m_b,
                                output logic [W-1:0] r, output logic [3:0] f, output logic il, output int lat);
    int n;
    int s;
    logic cf;
    logic vf;
    logic [31:0] p;
    r = '0; cf = 1'b0; vf = 1'b0; il = 1'b0; lat = 1; p = '0;
    n = (m_b >= 16'd16) ? 16 : int'(m_b);
    case (m_op)
      OP_ADD: begin
        s  = int'($signed(m_a)) + int'($signed(m_b));
        r  = m_a + m_b;
        cf = (32'(m_a) + 32'(m_b)) > 32'h0000_FFFF;
        vf = (s > 32767) || (s < -32768);
      end
      OP_SUB: begin
        s  = int'($signed(m_a)) - int'($signed(m_b));
        r  = m_a - m_b;
        cf = m_a < m_b;
        vf = (s > 32767) || (s < -32768);
      end
      OP_AND: r = m_a & m_b;
      OP_OR:  r = m_a | m_b;
      OP_XOR: r = m_a ^ m_b;
      OP_NOT: r = ~m_a;
      OP_SLL: begin
        r   = (n >= 16) ? '0 : (m_a << n);
        cf  = (n == 0) ? 1'b0 : m_a[16-n];
        lat = n + 1;
      end
      OP_SRL: begin
        r   = m_a >> n;
        cf  = (n == 0) ? 1'b0 : m_a[n-1];
        lat = n + 1;
      end
      OP_SRA: begin
        r   = $signed(m_a) >>> n;
        cf  = (n == 0) ? 1'b0 : m_a[n-1];
        lat = n + 1;
      end
      OP_ROL: begin
        n   = int'(m_b % 16'd16);
        r   = (n == 0) ? m_a : ((m_a << n) | (m_a >> (16 - n)));
        cf  = (n == 0) ? 1'b0 : r[0];
        lat = n + 1;
      end
      OP_ROR: begin
        n   = int'(m_b % 16'd16);
        r   = (n == 0) ? m_a : ((m_a >> n) | (m_a << (16 - n)));
        cf  = (n == 0) ? 1'b0 : r[15];
        lat = n + 1;
      end
`ifdef ALU_SEQ_MUL_EN
      4'd12: begin
        p   = 32'(m_a) * 32'(m_b);
        r   = p[15:0];
        cf  = p[31:16] != 16'h0;
        lat = 17;
      end
`endif
      default: il = 1'b1;
    endcase
    f = il ? 4'b0100 : {cf, (r == 16'h0), r[15], vf};
  endfunction

  // Presents one request, returns accept-to-out_valid latency; leaves DUT in DONE
  task automatic run_op(input logic [3:0] t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                        output int lat, output logic busy_ok);
    @(negedge clk_50M);
    in_valid = 1'b1; op = t_op; a = t_a; b = t_b;
    @(posedge clk_50M); #1;
    in_valid = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat <= 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk_50M); #1;
      lat++;
    end
  endtask

  task automatic finish_txn();
    out_ready = 1'b1;
    @(posedge clk_50M); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk_50M);
    #1;
    checks++;
    if ({result, flags, illegal, out_valid, busy, in_ready} !== {16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: res=%h flg=%b ill=%b ov=%b busy=%b ir=%b, want 0000/0000/0/0/0/1",
               result, flags, illegal, out_valid, busy, in_ready);
    end
    @(negedge clk_50M);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic [3:0]   f;
    logic         il;
    int           lat;
  } vec_t;

  task automatic test_directed();
    vec_t vecs[15];
    int lat;
    logic bok;
    vecs[0]  = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011, 1'b0, 1};
    vecs[1]  = '{OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 4'b1010, 1'b0, 1};
    vecs[2]  = '{OP_SUB, 16'h1234, 16'h1234, 16'h0000, 4'b0100, 1'b0, 1};
    vecs[3]  = '{OP_SRA, 16'h8000, 16'd20,   16'hFFFF, 4'b1010, 1'b0, 17};
    vecs[4]  = '{OP_ROL, 16'h8001, 16'd17,   16'h0003, 4'b1000, 1'b0, 2};
    vecs[5]  = '{OP_ROR, 16'h0001, 16'd0,    16'h0001, 4'b0000, 1'b0, 1};
`ifdef ALU_SEQ_MUL_EN
    vecs[6]  = '{4'd12,  16'h0100, 16'h0100, 16'h0000, 4'b1100, 1'b0, 17};
`else
    vecs[6]  = '{4'd12,  16'h0100, 16'h0100, 16'h0000, 4'b0100, 1'b1, 1};
`endif
    vecs[7]  = '{4'd0,   16'h0005, 16'h0005, 16'h0000, 4'b0100, 1'b1, 1};
    vecs[8]  = '{4'd15,  16'hFFFF, 16'h0001, 16'h0000, 4'b0100, 1'b1, 1};
    vecs[9]  = '{OP_NOT, 16'h00FF, 16'h0000, 16'hFF00, 4'b0010, 1'b0, 1};
    vecs[10] = '{OP_SLL, 16'h0001, 16'd16,   16'h0000, 4'b1100, 1'b0, 17};
    vecs[11] = '{OP_SRL, 16'h8000, 16'd15,   16'h0001, 4'b0000, 1'b0, 16};
    vecs[12] = '{OP_XOR, 16'h5555, 16'hFFFF, 16'hAAAA, 4'b0010, 1'b0, 1};
    vecs[13] = '{OP_ROR, 16'h0001, 16'd1,    16'h8000, 4'b1010, 1'b0, 2};
    vecs[14] = '{OP_SLL, 16'h1234, 16'd0,    16'h1234, 4'b0000, 1'b0, 1};
    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bok);
      checks++;
      if ({result, flags, illegal} !== {vecs[i].r, vecs[i].f, vecs[i].il}) begin
        errors++;
        $display("FAIL directed%0d value: got %h/%b/%b want %h/%b/%b", i, result, flags, illegal,
                 vecs[i].r, vecs[i].f, vecs[i].il);
      end
      checks++;
      if (lat != vecs[i].lat) begin
        errors++;
        $display("FAIL directed%0d latency: got %0d want %0d", i, lat, vecs[i].lat);
      end
      checks++;
      if (bok !== 1'b1) begin
        errors++;
        $display("FAIL directed%0d busy: busy dropped before out_valid, want high throughout", i);
      end
      finish_txn();
    end
  endtask

  task automatic test_random();
    logic [3:0]   o;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] er;
    logic [3:0]   ef;
    logic         eil;
    int           elat;
    int           lat;
    logic         bok;
    for (int i = 0; i < 60; i++) begin
      o  = 4'($urandom_range(0, 15));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
      model(o, ra, rb, er, ef, eil, elat);
      run_op(o, ra, rb, lat, bok);
      checks++;
      if ({result, flags, illegal} !== {er, ef, eil}) begin
        errors++;
        $display("FAIL random%0d op=%0d a=%h b=%h: got %h/%b/%b want %h/%b/%b", i, o, ra, rb,
                 result, flags, illegal, er, ef, eil);
      end
      checks++;
      if (lat != elat) begin
        errors++;
        $display("FAIL random%0d op=%0d latency: got %0d want %0d", i, o, lat, elat);
      end
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk_50M);
      #1;
      finish_txn();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic bok;
    run_op(OP_ADD, 16'h1111, 16'h2222, lat, bok);
    in_valid = 1'b1; op = OP_SUB; a = 16'h0009; b = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_50M); #1;
      checks++;
      if ({result, flags, illegal, out_valid, in_ready} !== {16'h3333, 4'b0000, 1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL backpressure%0d: got res=%h flg=%b ill=%b ov=%b ir=%b want 3333/0000/0/1/0",
                 i, result, flags, illegal, out_valid, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk_50M); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL release: got ir=%b ov=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
    end
    @(posedge clk_50M); #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL no_accept: got ir=%b ov=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    logic bok;
    int seen;
    run_op(OP_ADD, 16'h0001, 16'h0002, lat, bok);
    finish_txn();
    @(negedge clk_50M);
    in_valid = 1'b1; op = OP_SLL; a = 16'h00F0; b = 16'd10;
    @(posedge clk_50M); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk_50M);
    @(negedge clk_50M);
    checks++;
    if ({busy, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL mid_shift: got busy=%b ov=%b want 1/0", busy, out_valid);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, in_ready, result, flags} !== {1'b0, 1'b0, 1'b1, 16'h0, 4'h0}) begin
      errors++;
      $display("FAIL abort: got ov=%b busy=%b ir=%b res=%h flg=%b want 0/0/1/0000/0000",
               out_valid, busy, in_ready, result, flags);
    end
    @(negedge clk_50M);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_50M); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL stale_result: out_valid seen %0d cycles after abort, want 0", seen);
    end
    run_op(OP_ADD, 16'h0005, 16'h0006, lat, bok);
    checks++;
    if ({result, flags, lat} !== {16'h000B, 4'b0000, 1}) begin
      errors++;
      $display("FAIL recover: got %h/%b lat %0d want 000b/0000 lat 1", result, flags, lat);
    end
    finish_txn();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the board-level 16-bit ALU: WIDTH-bit operands, registered result plus {cf,zf,sf,vf} flags.
- Shift and rotate ops run iteratively, one bit per cycle, instead of as a combinational barrel shifter.
- Sits between an operand source (switch/UART front end or future CPU EX stage) and a result sink.
- One transaction in flight at a time.

Parameters:
- WIDTH, 16, operand/result width; power of two, >= 4.
- CNT_W, $clog2(WIDTH)+1, shift-counter width (derived; do not override).

Ports:
- clk_50M  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept; high only in IDLE.
- op  in  4  opcode: Add=1, Sub=2, And=3, Or=4, Xor=5, Not=6, Sll=7, Srl=8, Sra=9, Rol=10, Ror=11, Mul=12 (optional).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B / shift amount.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  sink accepts result.
- result  out  WIDTH  registered result.
- flags  out  4  {cf,zf,sf,vf}, registered.
- illegal  out  1  high with out_valid when op was unsupported.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; result=0, flags=0, illegal=0, out_valid=0, busy=0, in_ready=1.
  - Assertion mid-operation aborts the operation; no partial result is ever presented.
- States: IDLE, SHIFT, MUL (optional), DONE.
- IDLE, in_valid=1 at an edge: latch a, b, op.
  - Single-cycle op: compute, register result/flags, go to DONE. out_valid is high the next cycle (latency 1).
  - Sll/Srl/Sra: cnt = (b >= WIDTH) ? WIDTH : b[CNT_W-1:0].
  - Rol/Ror: cnt = b mod WIDTH.
  - Shift/rotate with cnt=0: go directly to DONE with result=a, cf=0.
  - Shift/rotate with cnt>0: go to SHIFT.
- SHIFT: move the working register one bit per cycle and decrement cnt.
  - At cnt reaching 0, go to DONE. Latency = cnt+1 cycles from accept to out_valid.
  - Sll/Srl fill with 0; Sra fills with the sign bit; Rol/Ror wrap the bit around.
  - cf = last bit shifted or rotated out.
- DONE: out_valid=1; result, flags and illegal held stable until out_ready=1 at an edge, then go to IDLE.
  - in_ready=0 in DONE, so no same-cycle accept. Minimum 2 cycles per transaction.
- Flags:
  - zf = (result==0) for all ops; sf = result[WIDTH-1] for all ops.
  - Add: cf = carry out of bit WIDTH-1; vf = signed overflow.
  - Sub: cf = borrow (a<b unsigned); vf = signed overflow (operand signs differ, result sign != a sign).
  - Logic ops, Not (~a): cf=0, vf=0.
  - Shifts/rotates: vf=0.
- Unsupported op (0, 13-15, or 12 without the macro): single-cycle, result=0, flags={0,1,0,0}, illegal=1.
- in_valid while busy is ignored; the source must hold its request until in_ready.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- ALU_SEQ_MUL_EN defined: op 12 = unsigned multiply, shift-add, exactly WIDTH cycles in MUL state (latency WIDTH+1).
  - result = low WIDTH bits of a*b.
  - cf = (high WIDTH bits != 0); vf=0; zf/sf from result.
- ALU_SEQ_MUL_EN undefined: no MUL state, no multiplier datapath; op 12 is illegal as above.

Test Plan (WIDTH=16):
- Add a=0x7FFF, b=0x0001 -> one cycle after accept: result=0x8000, flags=4'b0011, illegal=0.
- Sub a=0x0000, b=0x0001 -> result=0xFFFF, flags=4'b1010; Sub a=b=0x1234 -> result=0, flags=4'b0100.
- Sra a=0x8000, b=20 -> cnt clamped to 16; out_valid exactly 17 cycles after accept, result=0xFFFF, cf=1, sf=1; busy high throughout.
- Rol a=0x8001, b=17 -> cnt=1, result=0x0003, cf=1, latency 2. Ror a=0x0001, b=0 -> result=0x0001, latency 1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> result/flags stable, in_ready=0, a concurrent in_valid is not accepted. Then out_ready=1 -> IDLE and in_ready=1 next cycle.
- Reset: reset_n low mid-SHIFT (Sll b=10, after 4 cycles) -> immediately out_valid=0, busy=0, result=0. With ALU_SEQ_MUL_EN: Mul 0x0100*0x0100 -> result=0x0000, cf=1, zf=1 after 17 cycles. Without the macro: op 12 -> illegal=1.
